// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns host commands into spi_master transfers (opcode+address header, write data out or read data in) with completion on chip-select release
module spi_cmd_ctrl #(
  parameter int ADDR_BYTES = 3,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_wr,
  input  logic [7:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdata_vld,
  input  logic [7:0]       wdata,
  output logic             wdata_rdy,
  output logic             rdata_vld,
  output logic [7:0]       rdata,
  input  logic             rdata_rdy,
  output logic             busy,
  output logic             done,
  output logic             spi_start_pulse,
  output logic             tx_rx_seq,
  output logic [19:0]      tx_len,
  output logic [19:0]      rx_len,
  output logic             tx_buf_vld,
  output logic [7:0]       tx_buf_byte,
  input  logic             tx_buf_req,
  output logic             rx_buf_vld,
  input  logic [7:0]       rx_buf_byte,
  input  logic             rx_buf_req,
  input  logic             ncs
);
  typedef enum logic [2:0] {IDLE, START, HDR, WDAT, RDAT, WEND} state_t;
  localparam int SH = 8 * (4 - ADDR_BYTES);
  state_t state, nxt;
  logic [39:0] hdr;
  logic [2:0] hcnt;
  logic [LEN_W-1:0] cnt;
  logic wr, ncs_q, hdr_last, dec, accept;
  assign accept = state == IDLE && cmd_vld;
  assign hdr_last = hcnt == 3'(ADDR_BYTES);
  assign dec = cnt != '0 && ((state == WDAT && tx_buf_req && wdata_vld) || (state == RDAT && rx_buf_req));
  assign cmd_rdy = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == WEND && ncs && !ncs_q;
  assign spi_start_pulse = state == START;
  assign tx_rx_seq = 1'b0;
  assign tx_buf_vld = state == HDR || (state == WDAT && wdata_vld);
  assign tx_buf_byte = state == HDR ? hdr[39:32] : state == WDAT ? wdata : 8'h00;
  assign wdata_rdy = state == WDAT && tx_buf_req;
  assign rx_buf_vld = state == RDAT && rdata_rdy;
  assign rdata_vld = state == RDAT && rx_buf_req;
  assign rdata = state == RDAT ? rx_buf_byte : 8'h00;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = cmd_vld ? START : IDLE;
      START:      nxt = HDR;
      HDR:        nxt = !(tx_buf_req && hdr_last) ? HDR : cnt == '0 ? WEND : wr ? WDAT : RDAT;
      WDAT, RDAT: nxt = (cnt == '0 || (dec && cnt == LEN_W'(1))) ? WEND : state;
      WEND:       nxt = done ? IDLE : WEND;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hdr <= '0;
      hcnt <= '0;
      cnt <= '0;
      wr <= 1'b0;
      ncs_q <= 1'b1;
      tx_len <= '0;
      rx_len <= '0;
    end else begin
      state <= nxt;
      ncs_q <= ncs;
      if (accept) begin
        hdr <= {cmd_op, cmd_addr << SH};
        hcnt <= '0;
        cnt <= cmd_len;
        wr <= cmd_wr;
        tx_len <= 20'(1 + ADDR_BYTES) + (cmd_wr ? 20'(cmd_len) : 20'd0);
        rx_len <= cmd_wr ? 20'd0 : 20'(cmd_len);
      end else begin
        if (state == HDR && tx_buf_req) begin
          hdr <= {hdr[31:0], 8'h00};
          hcnt <= hcnt + 3'd1;
        end
        if (dec) cnt <= cnt - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed self-checking bench for spi_cmd_ctrl with a 3-byte and a 0-byte address build
module tb_spi_cmd_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_vld = 0, cmd_vld0 = 0, cmd_wr = 0;
  logic [7:0] cmd_op = 0, wdata = 0, rx_buf_byte = 0;
  logic [31:0] cmd_addr = 0;
  logic [15:0] cmd_len = 0;
  logic wdata_vld = 0, rdata_rdy = 0, tx_buf_req = 0, rx_buf_req = 0, ncs = 1;
  logic cmd_rdy, wdata_rdy, rdata_vld, busy, done, spi_start_pulse, tx_rx_seq, tx_buf_vld, rx_buf_vld;
  logic [7:0] rdata, tx_buf_byte;
  logic [19:0] tx_len, rx_len;
  logic cmd_rdy0, wdata_rdy0, rdata_vld0, busy0, done0, spi_start_pulse0, tx_rx_seq0, tx_buf_vld0, rx_buf_vld0;
  logic [7:0] rdata0, tx_buf_byte0;
  logic [19:0] tx_len0, rx_len0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  spi_cmd_ctrl #(.ADDR_BYTES(3), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_vld(wdata_vld), .wdata(wdata), .wdata_rdy(wdata_rdy),
    .rdata_vld(rdata_vld), .rdata(rdata), .rdata_rdy(rdata_rdy), .busy(busy), .done(done),
    .spi_start_pulse(spi_start_pulse), .tx_rx_seq(tx_rx_seq), .tx_len(tx_len), .rx_len(rx_len),
    .tx_buf_vld(tx_buf_vld), .tx_buf_byte(tx_buf_byte), .tx_buf_req(tx_buf_req), .rx_buf_vld(rx_buf_vld),
    .rx_buf_byte(rx_buf_byte), .rx_buf_req(rx_buf_req), .ncs(ncs));
  spi_cmd_ctrl #(.ADDR_BYTES(0), .LEN_W(16)) dut0 (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld0), .cmd_rdy(cmd_rdy0), .cmd_wr(cmd_wr), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_vld(wdata_vld), .wdata(wdata), .wdata_rdy(wdata_rdy0),
    .rdata_vld(rdata_vld0), .rdata(rdata0), .rdata_rdy(rdata_rdy), .busy(busy0), .done(done0),
    .spi_start_pulse(spi_start_pulse0), .tx_rx_seq(tx_rx_seq0), .tx_len(tx_len0), .rx_len(rx_len0),
    .tx_buf_vld(tx_buf_vld0), .tx_buf_byte(tx_buf_byte0), .tx_buf_req(tx_buf_req), .rx_buf_vld(rx_buf_vld0),
    .rx_buf_byte(rx_buf_byte), .rx_buf_req(rx_buf_req), .ncs(ncs));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic hdr_byte(input logic [7:0] e);
    chk("hdr_vld", 32'(tx_buf_vld), 1);
    chk("hdr_byte", 32'(tx_buf_byte), 32'(e));
    tx_buf_req = 1;
    tick;
    tx_buf_req = 0;
  endtask
  task automatic issue(input logic wr, input logic [7:0] op, input logic [31:0] addr, input logic [15:0] len);
    cmd_wr = wr; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_vld = 1;
    #1 chk("cmd_rdy_idle", 32'(cmd_rdy), 1);
    tick;
    cmd_vld = 0;
    ncs = 0;
    chk("start_pulse", 32'(spi_start_pulse), 1);
    chk("busy", 32'(busy), 1);
  endtask
  task automatic finish_cmd;
    ncs = 1;
    #1 chk("done_pulse", 32'(done), 1);
    tick;
    chk("done_once", 32'(done), 0);
    chk("idle_rdy", 32'(cmd_rdy), 1);
    chk("idle_busy", 32'(busy), 0);
  endtask
  initial begin
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txlen", 32'(tx_len), 0);
    chk("rst_txvld", 32'(tx_buf_vld), 0);
    rst = 0;
    tick;
    chk("rst_cmd_rdy", 32'(cmd_rdy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(spi_start_pulse), 0);
    // read 4 bytes from 0x123456
    issue(0, 8'h03, 32'h00123456, 16'd4);
    chk("rd_txlen", 32'(tx_len), 4);
    chk("rd_rxlen", 32'(rx_len), 4);
    chk("rd_seq", 32'(tx_rx_seq), 0);
    chk("rd_cmd_rdy", 32'(cmd_rdy), 0);
    tick;
    chk("rd_start_once", 32'(spi_start_pulse), 0);
    hdr_byte(8'h03);
    ncs = 1;
    tick;
    ncs = 0;
    chk("rd_early_edge", 32'(done), 0);
    hdr_byte(8'h12);
    hdr_byte(8'h34);
    hdr_byte(8'h56);
    chk("rd_rdat_txvld", 32'(tx_buf_vld), 0);
    rdata_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      rx_buf_byte = 8'hA0 + 8'(i);
      rx_buf_req = 1;
      #1 chk("rd_rxvld", 32'(rx_buf_vld), 1);
      chk("rd_rdata_vld", 32'(rdata_vld), 1);
      chk("rd_rdata", 32'(rdata), 32'(8'hA0 + 8'(i)));
      tick;
      rx_buf_req = 0;
    end
    rx_buf_req = 1;
    #1 chk("rd_end_rdvld", 32'(rdata_vld), 0);
    chk("rd_end_rxvld", 32'(rx_buf_vld), 0);
    rx_buf_req = 0;
    rdata_rdy = 0;
    chk("rd_len_hold", 32'(tx_len), 4);
    finish_cmd;
    // write AA,55 with gaps
    issue(1, 8'h02, 32'h00ABCDEF, 16'd2);
    chk("wr_txlen", 32'(tx_len), 6);
    chk("wr_rxlen", 32'(rx_len), 0);
    tick;
    hdr_byte(8'h02);
    hdr_byte(8'hAB);
    hdr_byte(8'hCD);
    hdr_byte(8'hEF);
    tx_buf_req = 1;
    #1 chk("wr_gap_vld", 32'(tx_buf_vld), 0);
    chk("wr_rdy_pass", 32'(wdata_rdy), 1);
    tick;
    wdata_vld = 1; wdata = 8'hAA;
    #1 chk("wr_b0_vld", 32'(tx_buf_vld), 1);
    chk("wr_b0", 32'(tx_buf_byte), 32'h AA);
    tick;
    wdata_vld = 0; tx_buf_req = 0;
    #1 chk("wr_rdy_noreq", 32'(wdata_rdy), 0);
    tick;
    wdata_vld = 1; wdata = 8'h55; tx_buf_req = 1;
    #1 chk("wr_b1", 32'(tx_buf_byte), 32'h55);
    tick;
    chk("wr_end_vld", 32'(tx_buf_vld), 0);
    chk("wr_end_rdy", 32'(wdata_rdy), 0);
    wdata_vld = 0; tx_buf_req = 0;
    finish_cmd;
    // read with zero length skips data phase
    issue(0, 8'h0B, 32'h00000100, 16'd0);
    chk("r0_txlen", 32'(tx_len), 4);
    chk("r0_rxlen", 32'(rx_len), 0);
    tick;
    hdr_byte(8'h0B);
    hdr_byte(8'h00);
    hdr_byte(8'h01);
    hdr_byte(8'h00);
    rdata_rdy = 1; rx_buf_req = 1;
    #1 chk("r0_rxvld", 32'(rx_buf_vld), 0);
    chk("r0_rdvld", 32'(rdata_vld), 0);
    rx_buf_req = 0;
    tick;
    chk("r0_wait", 32'(busy), 1);
    finish_cmd;
    // rdata_rdy stall
    rdata_rdy = 0;
    issue(0, 8'h03, 32'h00000200, 16'd2);
    tick;
    hdr_byte(8'h03);
    hdr_byte(8'h00);
    hdr_byte(8'h02);
    hdr_byte(8'h00);
    for (int i = 0; i < 20; i++) begin
      chk("st_rxvld", 32'(rx_buf_vld), 0);
      chk("st_rdvld", 32'(rdata_vld), 0);
      tick;
    end
    rdata_rdy = 1;
    #1 chk("st_release", 32'(rx_buf_vld), 1);
    for (int i = 0; i < 2; i++) begin
      rx_buf_byte = 8'h5A ^ 8'(i); rx_buf_req = 1;
      #1 chk("st_rdata", 32'(rdata), 32'(8'h5A ^ 8'(i)));
      tick;
      rx_buf_req = 0;
    end
    chk("st_end_rxvld", 32'(rx_buf_vld), 0);
    finish_cmd;
    // reset mid write
    issue(1, 8'h02, 32'h00000010, 16'd3);
    tick;
    hdr_byte(8'h02);
    hdr_byte(8'h00);
    hdr_byte(8'h00);
    hdr_byte(8'h10);
    wdata_vld = 1; wdata = 8'hC3; tx_buf_req = 1;
    tick;
    rst = 1;
    #1 chk("rs_busy", 32'(busy), 0);
    chk("rs_txvld", 32'(tx_buf_vld), 0);
    chk("rs_wrdy", 32'(wdata_rdy), 0);
    chk("rs_txlen", 32'(tx_len), 0);
    chk("rs_rxlen", 32'(rx_len), 0);
    chk("rs_byte", 32'(tx_buf_byte), 0);
    wdata_vld = 0; tx_buf_req = 0; ncs = 1;
    tick;
    rst = 0;
    tick;
    chk("rs_cmd_rdy", 32'(cmd_rdy), 1);
    issue(0, 8'h03, 32'h00000020, 16'd1);
    chk("rs_rd_txlen", 32'(tx_len), 4);
    chk("rs_rd_rxlen", 32'(rx_len), 1);
    tick;
    hdr_byte(8'h03);
    hdr_byte(8'h00);
    hdr_byte(8'h00);
    hdr_byte(8'h20);
    rx_buf_byte = 8'h3C; rx_buf_req = 1;
    #1 chk("rs_rdata", 32'(rdata), 32'h3C);
    tick;
    rx_buf_req = 0;
    finish_cmd;
    // cmd_vld held while busy
    cmd_wr = 0; cmd_op = 8'h03; cmd_addr = 32'h00000001; cmd_len = 16'd1; cmd_vld = 1;
    tick;
    ncs = 0;
    cmd_op = 8'h0B; cmd_addr = 32'h000A0B0C; cmd_len = 16'd2;
    #1 chk("hold_rdy", 32'(cmd_rdy), 0);
    chk("hold_rxlen", 32'(rx_len), 1);
    tick;
    hdr_byte(8'h03);
    hdr_byte(8'h00);
    hdr_byte(8'h00);
    hdr_byte(8'h01);
    rx_buf_byte = 8'h77; rx_buf_req = 1;
    tick;
    rx_buf_req = 0;
    chk("hold_wend_rdy", 32'(cmd_rdy), 0);
    ncs = 1;
    #1 chk("hold_done", 32'(done), 1);
    tick;
    chk("hold_idle_rdy", 32'(cmd_rdy), 1);
    tick;
    cmd_vld = 0; ncs = 0;
    chk("hold_2nd_start", 32'(spi_start_pulse), 1);
    chk("hold_2nd_rxlen", 32'(rx_len), 2);
    tick;
    chk("hold_2nd_op", 32'(tx_buf_byte), 32'h0B);
    rst = 1; ncs = 1; rdata_rdy = 0;
    tick;
    rst = 0;
    tick;
    // opcode-only header build
    cmd_wr = 0; cmd_op = 8'h9F; cmd_addr = 32'h11223344; cmd_len = 16'd0; cmd_vld0 = 1;
    tick;
    cmd_vld0 = 0; ncs = 0;
    chk("a0_start", 32'(spi_start_pulse0), 1);
    chk("a0_txlen", 32'(tx_len0), 1);
    chk("a0_main_idle", 32'(busy), 0);
    tick;
    chk("a0_vld", 32'(tx_buf_vld0), 1);
    chk("a0_op", 32'(tx_buf_byte0), 32'h9F);
    tx_buf_req = 1;
    tick;
    tx_buf_req = 0;
    chk("a0_hdr_end", 32'(tx_buf_vld0), 0);
    ncs = 1;
    #1 chk("a0_done", 32'(done0), 1);
    tick;
    chk("a0_rdy", 32'(cmd_rdy0), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
